imem_loader: RTL and testbench
==============================

# imem_loader

Writable instruction store with a byte-serial program-load port. It is the writer side of the instruction-fetch read path. It accepts a length-prefixed byte stream and assembles little-endian 32-bit words into an internal word array. While loading, it holds the pipeline in reset through `core_hold`. Once loaded, it serves fetches combinationally on a byte-addressed `ADDR`/`RD` port, in place of the fixed ROM.

## Interface
- `DEPTH`, default 16: number of 32-bit instruction words stored.
- `AW`, default 4: word-index width; `DEPTH` must equal 2^`AW`.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `load_req`, input, 1: pulse that restarts a load from the header.
- `in_valid`, input, 1: `in_byte` is valid.
- `in_ready`, output, 1: loader accepts a byte this cycle.
- `in_byte`, input, 8: stream byte.
- `ADDR`, input, 32: fetch byte address (PC).
- `RD`, output, 32: fetched instruction word, combinational.
- `core_hold`, output, 1: drive to the pipeline reset; 1 until a load completes.
- `load_done`, output, 1: load complete.
- `load_err`, output, 1: header word count exceeded `DEPTH`.
- `word_cnt`, output, `AW`+1: number of words written in the current load.

## Operation
- Stream format: byte 0 is N[7:0], byte 1 is N[15:8], then N×4 data bytes. Each word is sent LSB first.
- FSM states: LEN0 → LEN1 → DATA → DONE.
  - LEN0: on accept, latch N[7:0].
  - LEN1: on accept, latch N[15:8].
    - If N == 0, go straight to DONE.
    - Otherwise go to DATA. Set `load_err` if N > `DEPTH`.
  - DATA: bytes fill a 2-bit byte-lane counter.
    - On the 4th byte, write the assembled word to index `word_idx`, then increment the index.
    - Writes occur only while `word_idx` < `DEPTH`. Beyond that, bytes are consumed and discarded.
    - After word N is complete, go to DONE.
  - DONE: `in_ready` = 0. Stays in DONE until `load_req` or reset.
- `in_ready` = (state != DONE) && !`load_req`. A byte transfers on a rising edge where `in_valid` && `in_ready`.
- `load_req` in any state, on the next edge:
  - state → LEN0; byte lane, `word_idx`, `word_cnt` and `load_err` clear; `core_hold` → 1; `load_done` → 0.
  - Array contents are untouched but masked (see below).
- `word_cnt` = words actually written. It saturates at `DEPTH` because writes stop there.
- Read path:
  - Word index = `ADDR[AW+1:2]`. `ADDR[1:0]` is ignored.
  - `RD` = array[index] when `ADDR[31:AW+2]` == 0 and index < `word_cnt`; otherwise `RD` = 0.
  - Reads are active regardless of `core_hold`.
- `load_err` holds until the next `load_req` or reset. A completed erroneous load still reaches DONE after N words.

## Timing
- Reset (`rst` = 0), asynchronously:
  - state = LEN0, `in_ready` = 1, `core_hold` = 1, `load_done` = 0, `load_err` = 0, `word_cnt` = 0, byte lane = 0.
  - `RD` = 0 for every address. The array itself is not cleared.
- Reset asserted mid-load discards the partial word and any progress; the stream restarts at LEN0.
- Word write: the array entry and `word_cnt` update on the edge that accepts the 4th byte. `RD` reflects the new word in the cycle after that edge.
- Completion: on the edge accepting the final byte (or byte 1 of the header when N == 0), `core_hold` falls to 0 and `load_done` rises to 1. Both are registered.
- Throughput: one byte per cycle with `in_valid` held high. A full N-word load takes 2 + 4N accepted cycles.
- `in_valid` low stalls the FSM with no state change. `in_byte` is sampled only on a transfer.
- `load_req` and `in_valid` in the same cycle: no transfer occurs because `in_ready` = 0, and the restart takes effect.

## Test plan
- **Basic load.** After reset, stream 02 00, then EF BE AD DE, then 78 56 34 12 with `in_valid` held high. Required response:
  - `in_ready` = 1 for 10 cycles, then 0.
  - `load_done` = 1 and `core_hold` = 0 after the 10th edge; `word_cnt` = 2.
  - `RD`(0) = DEADBEEF, `RD`(4) = 12345678, `RD`(8) = 0, `RD`(1) = DEADBEEF.
- **Empty program.** Stream 00 00. Required: DONE after 2 accepts; `word_cnt` = 0; `RD`(0) = 0; `load_err` = 0.
- **Overflow with `DEPTH` = 16.** Header 14 00 (N = 20), then 80 bytes where each word value = its index. Required:
  - `load_err` = 1 after the header.
  - `word_cnt` = 16; `RD`(60) = 0000000F; `RD`(64) = 0.
  - DONE reached after 82 accepts.
- **Stalls and restart.** Toggle `in_valid` every other cycle during a 1-word load and check the same result as an unstalled load. Then pulse `load_req` while `in_valid` = 1. Required:
  - `in_ready` = 0 in the `load_req` cycle.
  - Next cycle: state LEN0, `core_hold` = 1, `word_cnt` = 0, `RD`(0) = 0.
- **Reset mid-word.** Send header 01 00 and 2 data bytes, then assert `rst` low asynchronously between edges. Required:
  - Outputs go to their reset values immediately.
  - A fresh stream 01 00 11 22 33 44 gives `RD`(0) = 44332211.

Source files
------------

// File: rtl/imem_loader_if.sv
// Program-load stream, fetch port and load status between a loader and its host.
interface imem_loader_if #(
  parameter int unsigned AW = 4
);
  logic        load_req;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic [31:0] ADDR;
  logic [31:0] RD;
  logic        core_hold;
  logic        load_done;
  logic        load_err;
  logic [AW:0] word_cnt;

  modport master (
    output load_req, in_valid, in_byte, ADDR,
    input  in_ready, RD, core_hold, load_done, load_err, word_cnt
  );

  modport slave (
    input  load_req, in_valid, in_byte, ADDR,
    output in_ready, RD, core_hold, load_done, load_err, word_cnt
  );
endinterface

// File: rtl/imem_loader.sv
// Writable instruction store loaded from a length-prefixed little-endian byte stream;
// holds the core in reset until the load completes and serves fetches combinationally.
module imem_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  localparam int unsigned NW = AW + 1;

  typedef enum logic [1:0] {LEN0, LEN1, DATA, DONE} state_t;

  state_t        state_q;
  logic [7:0]    len_lo_q;
  logic [15:0]   n_q;
  logic [1:0]    lane_q;
  logic [23:0]   buf_q;
  logic [15:0]   rcv_q;
  logic [NW-1:0] word_cnt_q;
  logic          load_err_q;
  logic          load_done_q;
  logic          core_hold_q;

  logic [31:0]   mem [DEPTH];

  logic          xfer;
  logic [15:0]   n_full;
  logic [31:0]   word;
  logic          wr_en;
  logic [AW-1:0] rd_idx;
  logic          rd_hit;
  logic          unused_addr_lo;

  assign bus.in_ready = (state_q != DONE) && !bus.load_req;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign n_full       = {bus.in_byte, len_lo_q};
  assign word         = {bus.in_byte, buf_q};
  // Words past the array end are still counted toward N but never stored.
  assign wr_en        = xfer && (state_q == DATA) && (lane_q == 2'd3) && (rcv_q < 16'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LEN0;
      len_lo_q    <= '0;
      n_q         <= '0;
      lane_q      <= '0;
      buf_q       <= '0;
      rcv_q       <= '0;
      word_cnt_q  <= '0;
      load_err_q  <= 1'b0;
      load_done_q <= 1'b0;
      core_hold_q <= 1'b1;
    end else if (bus.load_req) begin
      state_q     <= LEN0;
      lane_q      <= '0;
      rcv_q       <= '0;
      word_cnt_q  <= '0;
      load_err_q  <= 1'b0;
      load_done_q <= 1'b0;
      core_hold_q <= 1'b1;
    end else if (xfer) begin
      case (state_q)
        LEN0: begin
          len_lo_q <= bus.in_byte;
          state_q  <= LEN1;
        end
        LEN1: begin
          n_q <= n_full;
          if (n_full == 16'd0) begin
            state_q     <= DONE;
            load_done_q <= 1'b1;
            core_hold_q <= 1'b0;
          end else begin
            state_q    <= DATA;
            load_err_q <= (n_full > 16'(DEPTH));
          end
        end
        DATA: begin
          lane_q <= lane_q + 2'd1;
          // Shift bytes in from the top so byte 0 lands in bits [7:0].
          buf_q  <= {bus.in_byte, buf_q[23:8]};
          if (lane_q == 2'd3) begin
            rcv_q <= rcv_q + 16'd1;
            if (wr_en) begin
              word_cnt_q <= word_cnt_q + NW'(1);
            end
            if (rcv_q == n_q - 16'd1) begin
              state_q     <= DONE;
              load_done_q <= 1'b1;
              core_hold_q <= 1'b0;
            end
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  // Array is deliberately left out of reset; stale entries are masked by word_cnt.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[rcv_q[AW-1:0]] <= word;
    end
  end

  assign rd_idx         = bus.ADDR[AW+1:2];
  assign rd_hit         = (bus.ADDR[31:AW+2] == '0) && ({1'b0, rd_idx} < word_cnt_q);
  assign bus.RD         = rd_hit ? mem[rd_idx] : 32'd0;
  assign unused_addr_lo = ^bus.ADDR[1:0];

  assign bus.word_cnt  = word_cnt_q;
  assign bus.load_err  = load_err_q;
  assign bus.load_done = load_done_q;
  assign bus.core_hold = core_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-level reference model checked every cycle, plus directed literals.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  imem_loader_if #(.AW(4)) bus ();

  imem_loader #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int ready_cnt;

  // Reference model tracks position in the byte stream, not FSM states.
  int          m_k;
  int          m_n;
  int          m_cnt;
  bit          m_done;
  bit          m_err;
  logic [31:0] m_word;
  logic [31:0] m_mem [16];

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_restart();
    m_k = 0; m_n = 0; m_cnt = 0; m_done = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void m_accept(logic [7:0] b);
    int d, w, lane;
    m_k++;
    if (m_k == 1) begin
      m_n = int'(b);
    end else if (m_k == 2) begin
      m_n = m_n + int'(b) * 256;
      if (m_n == 0) m_done = 1'b1;
      else          m_err  = (m_n > 16);
    end else begin
      d    = m_k - 3;
      w    = d / 4;
      lane = d % 4;
      m_word[lane*8 +: 8] = b;
      if (lane == 3) begin
        if (w < 16) begin
          m_mem[w] = m_word;
          m_cnt    = w + 1;
        end
        if (w == m_n - 1) m_done = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] m_rd(logic [31:0] a);
    int idx;
    idx = int'(a[5:2]);
    if (a[31:6] == 26'd0 && idx < m_cnt) return m_mem[idx];
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready",  32'(bus.in_ready),  32'(!m_done && !bus.load_req));
      cmp("core_hold", 32'(bus.core_hold), 32'(!m_done));
      cmp("load_done", 32'(bus.load_done), 32'(m_done));
      cmp("load_err",  32'(bus.load_err),  32'(m_err));
      cmp("word_cnt",  32'(bus.word_cnt),  32'(m_cnt));
      cmp("rd",        bus.RD,             m_rd(bus.ADDR));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (bus.load_req)                         m_restart();
    else if (bus.in_valid && !m_done && rst)  m_accept(bus.in_byte);
    #1;
  endtask

  task automatic send(logic [7:0] b, logic v);
    bus.in_valid = v;
    bus.in_byte  = b;
    #1;
    if (bus.in_ready) ready_cnt++;
    tick();
  endtask

  task automatic restart();
    bus.load_req = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.load_req = 1'b0;
  endtask

  task automatic rd_lit(string nm, logic [31:0] a, logic [31:0] exp);
    bus.ADDR = a;
    #2;
    cmp(nm, bus.RD, exp);
  endtask

  logic [7:0] basic_bytes [10];
  logic [7:0] reset_bytes [6];

  initial begin
    basic_bytes = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    reset_bytes = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.ADDR     = 32'd0;
    m_restart();

    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    cmp("rst_ready", 32'(bus.in_ready), 32'd1);
    cmp("rst_hold",  32'(bus.core_hold), 32'd1);
    cmp("rst_cnt",   32'(bus.word_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Basic two-word load, then two extra valid cycles that must be refused.
    ready_cnt = 0;
    bus.ADDR  = 32'd4;
    foreach (basic_bytes[i]) send(basic_bytes[i], 1'b1);
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b1);
    bus.in_valid = 1'b0;
    cmp("basic_ready_cycles", 32'(ready_cnt), 32'd10);
    cmp("basic_done", 32'(bus.load_done), 32'd1);
    cmp("basic_hold", 32'(bus.core_hold), 32'd0);
    cmp("basic_cnt",  32'(bus.word_cnt),  32'd2);
    rd_lit("basic_rd0", 32'd0, 32'hDEADBEEF);
    rd_lit("basic_rd4", 32'd4, 32'h12345678);
    rd_lit("basic_rd8", 32'd8, 32'h00000000);
    rd_lit("basic_rd1", 32'd1, 32'hDEADBEEF);
    rd_lit("basic_rd_hi", 32'h0000_0100, 32'h00000000);

    // Empty program.
    restart();
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    bus.in_valid = 1'b0;
    cmp("empty_done", 32'(bus.load_done), 32'd1);
    cmp("empty_cnt",  32'(bus.word_cnt),  32'd0);
    cmp("empty_err",  32'(bus.load_err),  32'd0);
    rd_lit("empty_rd0", 32'd0, 32'h00000000);

    // Overflow: N = 20 words, word value = its index.
    restart();
    bus.ADDR = 32'd60;
    send(8'h14, 1'b1);
    send(8'h00, 1'b1);
    cmp("ovf_err_hdr", 32'(bus.load_err), 32'd1);
    for (int k = 0; k < 80; k++) begin
      send((k % 4 == 0) ? 8'(k / 4) : 8'h00, 1'b1);
      if (k == 78) cmp("ovf_not_done_81", 32'(bus.load_done), 32'd0);
    end
    bus.in_valid = 1'b0;
    cmp("ovf_done_82", 32'(bus.load_done), 32'd1);
    cmp("ovf_cnt",     32'(bus.word_cnt),  32'd16);
    cmp("ovf_err",     32'(bus.load_err),  32'd1);
    rd_lit("ovf_rd60", 32'd60, 32'h0000000F);
    rd_lit("ovf_rd64", 32'd64, 32'h00000000);

    // Stalled one-word load.
    restart();
    bus.ADDR = 32'd0;
    foreach (basic_bytes[i]) begin
      if (i < 6) begin
        send((i == 0) ? 8'h01 : (i == 1) ? 8'h00 : (i == 2) ? 8'h0D :
             (i == 3) ? 8'hF0 : (i == 4) ? 8'hFE : 8'hCA, 1'b1);
        send(8'h99, 1'b0);
      end
    end
    cmp("stall_done", 32'(bus.load_done), 32'd1);
    cmp("stall_cnt",  32'(bus.word_cnt),  32'd1);
    rd_lit("stall_rd0", 32'd0, 32'hCAFEF00D);

    // Restart with in_valid high in the same cycle.
    bus.load_req = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h55;
    #2;
    cmp("req_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    cmp("req_hold",  32'(bus.core_hold), 32'd1);
    cmp("req_cnt",   32'(bus.word_cnt),  32'd0);
    cmp("req_ready_after", 32'(bus.in_ready), 32'd1);
    rd_lit("req_rd0", 32'd0, 32'h00000000);

    // Reset in the middle of a word.
    send(8'h01, 1'b1);
    send(8'h00, 1'b1);
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b1);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    m_restart();
    #1;
    cmp("mrst_ready", 32'(bus.in_ready),  32'd1);
    cmp("mrst_hold",  32'(bus.core_hold), 32'd1);
    cmp("mrst_done",  32'(bus.load_done), 32'd0);
    cmp("mrst_cnt",   32'(bus.word_cnt),  32'd0);
    cmp("mrst_rd0",   bus.RD,             32'h00000000);
    @(posedge clk);
    #1 rst = 1'b1;
    foreach (reset_bytes[i]) send(reset_bytes[i], 1'b1);
    bus.in_valid = 1'b0;
    cmp("mrst_done_after", 32'(bus.load_done), 32'd1);
    rd_lit("mrst_rd0_after", 32'd0, 32'h44332211);

    tick();
    tick();
    chk_en = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
